// File: rtl/axo_defines.sv
// Shared constants and types for the axo writeback path.
package axo_defines;
   localparam int unsigned AXO_NREGS  = 32;
   localparam int unsigned AXO_RIDX_W = $clog2(AXO_NREGS);

   typedef enum logic {AXO_WB_ALU, AXO_WB_MEM} axo_wb_src_t;
endpackage

// File: rtl/axo_scoreboard.sv
// Busy scoreboard for in-flight destination registers, with the issue-stage hazard compare.
module axo_scoreboard
   import axo_defines::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  iss_valid,
   input  logic                  iss_has_rs1,
   input  logic                  iss_has_rs2,
   input  logic                  iss_has_rd,
   input  logic [AXO_RIDX_W-1:0] iss_rs1,
   input  logic [AXO_RIDX_W-1:0] iss_rs2,
   input  logic [AXO_RIDX_W-1:0] iss_rd,
   input  logic                  clr_en,
   input  logic [AXO_RIDX_W-1:0] clr_idx,
   input  logic [AXO_RIDX_W-1:0] chk_idx,
   output logic                  hazard_c,
   output logic                  chk_busy_c
);

   logic [AXO_NREGS-1:1] busy_q;
   logic [AXO_NREGS-1:0] busy_all;
   logic                 set_en;

   // x0 is never tracked, so its slot reads as a constant zero
   assign busy_all   = {busy_q, 1'b0};
   assign hazard_c   = iss_valid & ((iss_has_rs1 & busy_all[iss_rs1]) |
                                    (iss_has_rs2 & busy_all[iss_rs2]) |
                                    (iss_has_rd  & busy_all[iss_rd]));
   assign set_en     = iss_valid & ~hazard_c & iss_has_rd & (iss_rd != '0);
   assign chk_busy_c = busy_all[chk_idx];

   // set takes priority over a clear of the same index on the same edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q <= '0;
      end else begin
         for (int unsigned i = 1; i < AXO_NREGS; i++) begin
            if (set_en && (iss_rd == AXO_RIDX_W'(i))) begin
               busy_q[i] <= 1'b1;
            end else if (clr_en && (clr_idx == AXO_RIDX_W'(i))) begin
               busy_q[i] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/axo_wb_arbiter.sv
// Round-robin ALU/load writeback arbiter driving the single register file write port.
module axo_wb_arbiter
   import axo_defines::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  iss_valid,
   input  logic                  iss_has_rs1,
   input  logic                  iss_has_rs2,
   input  logic                  iss_has_rd,
   input  logic [AXO_RIDX_W-1:0] iss_rs1,
   input  logic [AXO_RIDX_W-1:0] iss_rs2,
   input  logic [AXO_RIDX_W-1:0] iss_rd,
   output logic                  hazard,
   input  logic                  alu_valid,
   input  logic [AXO_RIDX_W-1:0] alu_rd,
   input  logic [XLEN-1:0]       alu_data,
   output logic                  alu_ready,
   input  logic                  mem_valid,
   input  logic [AXO_RIDX_W-1:0] mem_rd,
   input  logic [XLEN-1:0]       mem_data,
   output logic                  mem_ready,
   output logic                  rf_we,
   output logic [AXO_RIDX_W-1:0] rf_rd,
   output logic [XLEN-1:0]       rf_din,
   output logic                  err
);

   axo_wb_src_t           last_grant_q;
   logic                  alu_gnt_c;
   logic                  mem_gnt_c;
   logic                  any_gnt_c;
   logic [AXO_RIDX_W-1:0] gnt_rd_c;
   logic [XLEN-1:0]       gnt_data_c;
   logic                  gnt_busy_c;

   // on contention the requester that did not win last time is granted
   always_comb begin
      alu_gnt_c = 1'b0;
      mem_gnt_c = 1'b0;
      if (alu_valid && mem_valid) begin
         if (last_grant_q == AXO_WB_MEM) begin
            alu_gnt_c = 1'b1;
         end else begin
            mem_gnt_c = 1'b1;
         end
      end else begin
         alu_gnt_c = alu_valid;
         mem_gnt_c = mem_valid;
      end
   end

   assign any_gnt_c  = alu_gnt_c | mem_gnt_c;
   assign gnt_rd_c   = mem_gnt_c ? mem_rd   : alu_rd;
   assign gnt_data_c = mem_gnt_c ? mem_data : alu_data;
   assign alu_ready  = alu_gnt_c;
   assign mem_ready  = mem_gnt_c;

   axo_scoreboard u_scoreboard (
      .clk         (clk),
      .rst         (rst),
      .iss_valid   (iss_valid),
      .iss_has_rs1 (iss_has_rs1),
      .iss_has_rs2 (iss_has_rs2),
      .iss_has_rd  (iss_has_rd),
      .iss_rs1     (iss_rs1),
      .iss_rs2     (iss_rs2),
      .iss_rd      (iss_rd),
      .clr_en      (rf_we),
      .clr_idx     (rf_rd),
      .chk_idx     (gnt_rd_c),
      .hazard_c    (hazard),
      .chk_busy_c  (gnt_busy_c)
   );

   // winner is registered for one cycle; writes to x0 are accepted but suppressed
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_we        <= 1'b0;
         rf_rd        <= '0;
         rf_din       <= '0;
         err          <= 1'b0;
         last_grant_q <= AXO_WB_MEM;
      end else begin
         rf_we <= any_gnt_c & (gnt_rd_c != '0);
         if (any_gnt_c) begin
            rf_rd        <= gnt_rd_c;
            rf_din       <= gnt_data_c;
            last_grant_q <= alu_gnt_c ? AXO_WB_ALU : AXO_WB_MEM;
         end
         if (any_gnt_c && (gnt_rd_c != '0) && !gnt_busy_c) begin
            err <= 1'b1;
         end
      end
   end

endmodule
